// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control path: opcodes,
// FSM state encodings and the codes driven onto the datapath selects.
package cpu_ctrl_pkg;

    localparam int OPW = 6;
    localparam int STW = 3;

    typedef enum logic [2:0] {
        sIF     = 3'b000,
        sID     = 3'b001,
        sEXE_LS = 3'b010,
        sMEM    = 3'b011,
        sWB_L   = 3'b100,
        sEXE_BR = 3'b101,
        sEXE_AL = 3'b110,
        sWB_AL  = 3'b111
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_XORI  = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b100110;
    localparam logic [5:0] OP_SLT   = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_ULT = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    // PC source select
    localparam logic [1:0] PCSRC_PC4  = 2'b00;
    localparam logic [1:0] PCSRC_BR   = 2'b01;
    localparam logic [1:0] PCSRC_RS   = 2'b10;
    localparam logic [1:0] PCSRC_JUMP = 2'b11;

    // Destination register select
    localparam logic [1:0] REGDST_RA = 2'b00;
    localparam logic [1:0] REGDST_RT = 2'b01;
    localparam logic [1:0] REGDST_RD = 2'b10;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of ALU-class opcodes into ALU controls and the
// write-back destination; 'defined' flags opcodes that run through sEXE_AL.
module alu_op_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic       ext_sel,
    output logic [1:0] reg_dst,
    output logic       defined
);

    // Opcode table lookup; R-types write rd, I-types write rt
    always_comb begin
        alu_op    = ALU_ADD;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        ext_sel   = 1'b0;
        reg_dst   = REGDST_RD;
        defined   = 1'b1;
        case (opcode)
            OP_ADD:   alu_op = ALU_ADD;
            OP_SUB:   alu_op = ALU_SUB;
            OP_AND:   alu_op = ALU_AND;
            OP_SLT:   alu_op = ALU_SLT;
            OP_SLL: begin
                alu_op    = ALU_SLL;
                alu_src_a = 1'b1;
            end
            OP_ADDIU: begin
                alu_op = ALU_ADD; alu_src_b = 1'b1; ext_sel = 1'b1; reg_dst = REGDST_RT;
            end
            OP_ANDI: begin
                alu_op = ALU_AND; alu_src_b = 1'b1; reg_dst = REGDST_RT;
            end
            OP_ORI: begin
                alu_op = ALU_OR; alu_src_b = 1'b1; reg_dst = REGDST_RT;
            end
            OP_XORI: begin
                alu_op = ALU_XOR; alu_src_b = 1'b1; reg_dst = REGDST_RT;
            end
            OP_SLTI: begin
                alu_op = ALU_SLT; alu_src_b = 1'b1; ext_sel = 1'b1; reg_dst = REGDST_RT;
            end
            default: defined = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: steps each instruction through fetch,
// decode, execute, memory and write-back, driving all datapath controls.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 3
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           PCWre,
    output logic           IRWre,
    output logic           ALUSrcA,
    output logic           ALUSrcB,
    output logic [2:0]     ALUOp,
    output logic           ExtSel,
    output logic [1:0]     RegDst,
    output logic           RegWre,
    output logic           WrRegDSrc,
    output logic           DBDataSrc,
    output logic           mRD,
    output logic           mWR,
    output logic [1:0]     PCSrc,
    output logic [STW-1:0] state
);

    state_t     state_q, state_d;
    logic [2:0] dec_alu_op;
    logic       dec_src_a, dec_src_b, dec_ext, dec_defined;
    logic [1:0] dec_reg_dst;
    logic       br_taken;

    alu_op_decode u_dec (
        .opcode    (opcode),
        .alu_op    (dec_alu_op),
        .alu_src_a (dec_src_a),
        .alu_src_b (dec_src_b),
        .ext_sel   (dec_ext),
        .reg_dst   (dec_reg_dst),
        .defined   (dec_defined)
    );

    // bltz runs slt against $0, so a clear zero flag means "less than zero"
    assign br_taken = ((opcode == OP_BEQ) &&  zero) ||
                      ((opcode == OP_BNE) && !zero) ||
                      ((opcode == OP_BLTZ) && !zero);

    // State register; reset always returns to fetch without touching the PC
    always_ff @(posedge CLK) begin
        if (Reset) state_q <= sIF;
        else       state_q <= state_d;
    end

    // Next-state and per-state controls; Reset overrides everything to 0
    always_comb begin
        state_d   = state_q;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = ALU_ADD;
        ExtSel    = 1'b0;
        RegDst    = REGDST_RA;
        RegWre    = 1'b0;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        PCSrc     = PCSRC_PC4;
        state     = state_q;
        case (state_q)
            sIF: begin
                IRWre   = 1'b1;
                state_d = sID;
            end
            sID: begin
                case (opcode)
                    OP_J: begin
                        PCWre = 1'b1; PCSrc = PCSRC_JUMP; state_d = sIF;
                    end
                    OP_JR: begin
                        PCWre = 1'b1; PCSrc = PCSRC_RS; state_d = sIF;
                    end
                    OP_JAL: begin
                        PCWre = 1'b1; PCSrc = PCSRC_JUMP; RegWre = 1'b1;
                        RegDst = REGDST_RA; WrRegDSrc = 1'b0; state_d = sIF;
                    end
                    OP_HALT: state_d = sID;
                    OP_BEQ, OP_BNE, OP_BLTZ: state_d = sEXE_BR;
                    OP_LW, OP_SW: state_d = sEXE_LS;
                    default: begin
                        if (dec_defined) begin
                            state_d = sEXE_AL;
                        end else begin
                            // unknown opcode retires as a NOP
                            PCWre = 1'b1; PCSrc = PCSRC_PC4; state_d = sIF;
                        end
                    end
                endcase
            end
            sEXE_AL, sWB_AL: begin
                ALUOp   = dec_alu_op;
                ALUSrcA = dec_src_a;
                ALUSrcB = dec_src_b;
                ExtSel  = dec_ext;
                state_d = sWB_AL;
                if (state_q == sWB_AL) begin
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    DBDataSrc = 1'b0;
                    RegDst    = dec_reg_dst;
                    PCWre     = 1'b1;
                    PCSrc     = PCSRC_PC4;
                    state_d   = sIF;
                end
            end
            sEXE_BR: begin
                ALUOp   = (opcode == OP_BLTZ) ? ALU_SLT : ALU_SUB;
                PCWre   = 1'b1;
                PCSrc   = br_taken ? PCSRC_BR : PCSRC_PC4;
                state_d = sIF;
            end
            sEXE_LS, sMEM: begin
                ALUOp   = ALU_ADD;
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                state_d = sMEM;
                if (state_q == sMEM) begin
                    if (opcode == OP_LW) begin
                        mRD     = 1'b1;
                        state_d = sWB_L;
                    end else begin
                        mWR     = 1'b1;
                        PCWre   = 1'b1;
                        PCSrc   = PCSRC_PC4;
                        state_d = sIF;
                    end
                end
            end
            sWB_L: begin
                mRD       = 1'b1;
                DBDataSrc = 1'b1;
                WrRegDSrc = 1'b1;
                RegDst    = REGDST_RT;
                RegWre    = 1'b1;
                PCWre     = 1'b1;
                PCSrc     = PCSRC_PC4;
                state_d   = sIF;
            end
            default: state_d = sIF;
        endcase
        if (Reset) begin
            PCWre     = 1'b0;
            IRWre     = 1'b0;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 1'b0;
            ALUOp     = 3'b000;
            ExtSel    = 1'b0;
            RegDst    = 2'b00;
            RegWre    = 1'b0;
            WrRegDSrc = 1'b0;
            DBDataSrc = 1'b0;
            mRD       = 1'b0;
            mWR       = 1'b0;
            PCSrc     = 2'b00;
            state     = sIF;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into
// its expected per-cycle control words from the opcode table and compared.
module tb_multicycle_ctrl;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] opcode;
    logic       zero;
    logic       PCWre, IRWre, ALUSrcA, ALUSrcB, ExtSel, RegWre, WrRegDSrc, DBDataSrc, mRD, mWR;
    logic [2:0] ALUOp;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    logic [19:0] exp_q[$];
    logic [19:0] got;

    always #5 CLK = ~CLK;

    multicycle_ctrl dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ExtSel(ExtSel), .RegDst(RegDst), .RegWre(RegWre),
        .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR),
        .PCSrc(PCSrc), .state(state)
    );

    // {state,PCWre,IRWre,SrcA,SrcB,ALUOp,Ext,RegDst,RegWre,WrRegDSrc,DBDataSrc,mRD,mWR,PCSrc}
    assign got = {state, PCWre, IRWre, ALUSrcA, ALUSrcB, ALUOp, ExtSel, RegDst,
                  RegWre, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc};

    task automatic check_eq(input string tag, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", tag, act, exp);
        end
    endtask

    function automatic logic [19:0] w(input int st, input bit pcw, input bit irw,
                                      input bit sa, input bit sb, input int aop,
                                      input bit ext, input int rd, input bit rw,
                                      input bit wrs, input bit dbs, input bit mrd,
                                      input bit mwr, input int psrc);
        return {st[2:0], pcw, irw, sa, sb, aop[2:0], ext, rd[1:0], rw, wrs, dbs, mrd, mwr, psrc[1:0]};
    endfunction

    // Opcode table for ALU-class instructions
    function automatic bit alu_info(input logic [5:0] op, output int aop, output bit sa,
                                    output bit sb, output bit ext, output bit rtype);
        sa = 0; sb = 0; ext = 0; rtype = 1; aop = 0;
        case (op)
            6'b000000: aop = 0;
            6'b000001: aop = 1;
            6'b010000: aop = 6;
            6'b100111: aop = 3;
            6'b011000: begin aop = 4; sa = 1; end
            6'b000010: begin aop = 0; sb = 1; ext = 1; rtype = 0; end
            6'b010001: begin aop = 6; sb = 1; rtype = 0; end
            6'b010010: begin aop = 5; sb = 1; rtype = 0; end
            6'b010011: begin aop = 7; sb = 1; rtype = 0; end
            6'b100110: begin aop = 3; sb = 1; ext = 1; rtype = 0; end
            default: return 0;
        endcase
        return 1;
    endfunction

    // Expected cycle-by-cycle control words for one instruction
    task automatic build(input logic [5:0] op, input bit z, input int hold);
        int aop; bit sa, sb, ext, rt, take;
        exp_q.delete();
        exp_q.push_back(w(0,0,1,0,0,0,0,0,0,0,0,0,0,0));
        case (op)
            6'b111000: exp_q.push_back(w(1,1,0,0,0,0,0,0,0,0,0,0,0,3));
            6'b111001: exp_q.push_back(w(1,1,0,0,0,0,0,0,0,0,0,0,0,2));
            6'b111010: exp_q.push_back(w(1,1,0,0,0,0,0,0,1,0,0,0,0,3));
            6'b111111: for (int i = 0; i < hold; i++) exp_q.push_back(w(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
            6'b110100, 6'b110101, 6'b110110: begin
                take = (op == 6'b110100) ? z : !z;
                exp_q.push_back(w(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
                exp_q.push_back(w(5,1,0,0,0,(op == 6'b110110) ? 3 : 1,0,0,0,0,0,0,0, take ? 1 : 0));
            end
            6'b110000, 6'b110001: begin
                exp_q.push_back(w(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
                exp_q.push_back(w(2,0,0,0,1,0,1,0,0,0,0,0,0,0));
                if (op == 6'b110000) begin
                    exp_q.push_back(w(3,1,0,0,1,0,1,0,0,0,0,0,1,0));
                end else begin
                    exp_q.push_back(w(3,0,0,0,1,0,1,0,0,0,0,1,0,0));
                    exp_q.push_back(w(4,1,0,0,0,0,0,1,1,1,1,1,0,0));
                end
            end
            default: begin
                if (alu_info(op, aop, sa, sb, ext, rt)) begin
                    exp_q.push_back(w(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
                    exp_q.push_back(w(6,0,0,sa,sb,aop,ext,0,0,0,0,0,0,0));
                    exp_q.push_back(w(7,1,0,sa,sb,aop,ext, rt ? 2 : 1,1,1,0,0,0,0));
                end else begin
                    exp_q.push_back(w(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
                end
            end
        endcase
    endtask

    // Run one instruction; Reset is raised in cycle 'abort' (if within range)
    task automatic run_instr(input logic [5:0] op, input bit z, input int hold, input int abort);
        build(op, z, hold);
        opcode = op;
        zero   = z;
        for (int i = 0; i <= exp_q.size(); i++) begin
            if (i == abort) Reset = 1'b1;
            if (i == exp_q.size() && i != abort) break;
            @(negedge CLK);
            check_eq($sformatf("op%06b z%0d cyc%0d", op, z, i), got,
                     (i == abort) ? 20'h0 : exp_q[i]);
            @(posedge CLK);
            #1;
            if (i == abort) begin
                Reset = 1'b0;
                break;
            end
        end
        $display("instr op=%06b zero=%0d cycles=%0d abort=%0d", op, z, exp_q.size(), abort);
    endtask

    logic [5:0] defined_ops [19] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000,
        6'b010001, 6'b010010, 6'b010011, 6'b011000, 6'b100110, 6'b100111,
        6'b110000, 6'b110001, 6'b110100, 6'b110101, 6'b110110, 6'b111000,
        6'b111001, 6'b111010, 6'b111111};

    function automatic bit is_defined(input logic [5:0] op);
        foreach (defined_ops[k]) if (defined_ops[k] == op) return 1;
        return 0;
    endfunction

    initial begin
        logic [5:0] op;
        int ab;
        Reset = 1'b1; opcode = 6'b0; zero = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            check_eq("reset outputs", got, 20'h0);
            @(posedge CLK);
            #1;
        end
        Reset = 1'b0;

        // directed cases from the plan
        run_instr(6'b000000, 0, 0, -1);   // add
        run_instr(6'b110100, 1, 0, -1);   // beq taken
        run_instr(6'b110100, 0, 0, -1);   // beq not taken
        run_instr(6'b110101, 0, 0, -1);   // bne taken
        run_instr(6'b110001, 0, 0, -1);   // lw
        run_instr(6'b110000, 0, 0, -1);   // sw
        run_instr(6'b111010, 0, 0, -1);   // jal
        run_instr(6'b111111, 0, 20, 21);  // halt 20 cycles then reset
        run_instr(6'b110000, 0, 0, 3);    // reset during sMEM of sw
        run_instr(6'b101010, 0, 0, -1);   // undefined -> NOP
        run_instr(6'b110110, 0, 0, -1);   // bltz taken
        run_instr(6'b011000, 1, 0, -1);   // sll

        // random mix
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                do op = 6'($urandom_range(0, 63)); while (is_defined(op));
            end else begin
                op = defined_ops[$urandom_range(0, 18)];
            end
            build(op, 0, 3);
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, exp_q.size() - 1) : -1;
            if (op == 6'b111111) ab = 1 + $urandom_range(0, 3);
            run_instr(op, 1'($urandom_range(0, 1)), 3, ab);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multi-cycle CPU.
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Drives every datapath control, including the 3-bit ALUOp consumed by the ALU, and reacts to the ALU's zero flag for branches.
- Sits between the instruction register (opcode) and the datapath muxes and enables.

Parameters:
- OPW, 6, opcode width.
- STW, 3, state register width.

Ports:
- CLK  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- opcode  in  6  instruction bits [31:26] from the IR.
- zero  in  1  ALU zero flag, registered in the datapath.
- PCWre  out  1  PC load enable.
- IRWre  out  1  instruction register load enable.
- ALUSrcA  out  1  0 = rs, 1 = shamt.
- ALUSrcB  out  1  0 = rt, 1 = extended immediate.
- ALUOp  out  3  000 add, 001 sub, 010 ult, 011 slt, 100 sll, 101 or, 110 and, 111 xor.
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend.
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd.
- RegWre  out  1  register-file write enable.
- WrRegDSrc  out  1  0 = PC+4 (jal), 1 = DB bus.
- DBDataSrc  out  1  0 = ALU result, 1 = data memory.
- mRD  out  1  data-memory read.
- mWR  out  1  data-memory write.
- PCSrc  out  2  00 PC+4, 01 branch target, 10 rs (jr), 11 jump target.
- state  out  3  current state, for debug.

Behaviour:
- Clock and reset: one clock CLK. Reset is synchronous and active-high; it is sampled only on the CLK rising edge.
- Reset action: when Reset=1 at an edge, state becomes sIF.
- Outputs during Reset: all write enables (PCWre, IRWre, RegWre, mWR, mRD) are forced to 0 combinationally. Every other output is 0.
- Reset mid-instruction: the current instruction is abandoned with no register or memory write. The PC keeps its value, so execution refetches the same instruction.
- States: sIF=000, sID=001, sEXE_LS=010, sMEM=011, sWB_L=100, sEXE_BR=101, sEXE_AL=110, sWB_AL=111.
- Output structure: outputs are combinational from the registered state and opcode; PCSrc also depends on zero. Any output not listed for a state is 0.
- sIF: IRWre=1. Next state is sID.
- sID:
  - j, jal, jr: PCWre=1 and PCSrc=11/11/10. jal also sets RegWre=1, RegDst=00, WrRegDSrc=0. Next state is sIF.
  - halt: PCWre=0; the FSM stays in sID until Reset.
  - beq, bne, bltz: next state is sEXE_BR.
  - lw, sw: next state is sEXE_LS.
  - Defined ALU opcodes: next state is sEXE_AL.
  - Undefined opcode: PCWre=1, PCSrc=00 (executes as a NOP), next state is sIF.
- sEXE_AL: drives ALUOp, ALUSrcA, ALUSrcB, ExtSel per the opcode table. Next state is sWB_AL.
- sWB_AL: keeps the sEXE_AL controls and adds RegWre=1, WrRegDSrc=1, DBDataSrc=0. RegDst=10 for R-type, 01 for I-type. PCWre=1, PCSrc=00. Next state is sIF.
- sEXE_BR: ALUOp=001 for beq/bne; ALUOp=011 with B=$0 for bltz. PCWre=1.
  - PCSrc=01 if (beq & zero) or (bne & ~zero) or (bltz & ~zero); otherwise 00.
  - Next state is sIF.
- sEXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1. Next state is sMEM.
- sMEM: keeps the sEXE_LS controls.
  - sw: mWR=1, PCWre=1, PCSrc=00, next state is sIF.
  - lw: mRD=1, next state is sWB_L.
- sWB_L: mRD=1, DBDataSrc=1, WrRegDSrc=1, RegDst=01, RegWre=1, PCWre=1, PCSrc=00. Next state is sIF.
- Latency in CPI:
  - ALU instructions: 4.
  - Branches: 3.
  - sw: 4.
  - lw: 5.
  - j, jal, jr: 2.
- PCWre is high in exactly one cycle per instruction: the last one.
- Opcode table (opcode: ALUOp, B source, extension):
  - add 000000: 000, rt.
  - sub 000001: 001, rt.
  - addiu 000010: 000, imm, sign.
  - and 010000: 110, rt.
  - andi 010001: 110, imm, zero.
  - ori 010010: 101, imm, zero.
  - xori 010011: 111, imm, zero.
  - sll 011000: 100, ALUSrcA=1.
  - slti 100110: 011, imm, sign.
  - slt 100111: 011, rt.
  - sw 110000.
  - lw 110001.
  - beq 110100.
  - bne 110101.
  - bltz 110110.
  - j 111000.
  - jr 111001.
  - jal 111010.
  - halt 111111.

Decomposition:
- Shared package cpu_ctrl_pkg: opcode constants, state encodings, ALUOp codes, PCSrc and RegDst codes.
- Sub-module alu_op_decode: purely combinational, opcode -> {ALUOp, ALUSrcA, ALUSrcB, ExtSel, RegDst, defined}.
- multicycle_ctrl owns the state register, next-state logic and enable gating.

Test Plan:
- Reset=1 for 2 edges, then release -> state=000 and all enables 0 while Reset is high. IRWre=1 in the first cycle after release.
- opcode=000000 (add) -> states 000,001,110,111,000. ALUOp=000 in sEXE_AL and sWB_AL. RegWre=1 and PCWre=1 only in sWB_AL, with RegDst=10.
- opcode=110100 (beq), zero=1 -> 3 cycles with PCSrc=01 in sEXE_BR. Repeat with zero=0 -> PCSrc=00. bne with zero=0 -> PCSrc=01.
- opcode=110001 (lw) -> 5 cycles, mRD=1 in sMEM and sWB_L, RegWre=1 only in sWB_L. opcode=110000 (sw) -> mWR=1 for exactly 1 cycle, then sIF.
- opcode=111010 (jal) -> 2 cycles; sID shows PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0. opcode=111111 (halt) -> the FSM holds in sID with PCWre=0 for 20 cycles.
- Reset asserted in sMEM of sw -> mWR=0 in that cycle and state=000 at the next edge. opcode=101010 (undefined) -> 2-cycle NOP with PCWre=1 in sID.
